// File: rtl/mcb_pkg.sv
// Shared MCB definitions: instruction encodings, mask polarity, frame-writer FSM states.
package mcb_pkg;

  localparam logic [2:0] MCB_WR = 3'b000;
  localparam logic [2:0] MCB_RD = 3'b001;

  // A set mask bit tells the MCB to leave that byte untouched.
  localparam logic MASK_SKIP = 1'b1;

  typedef enum logic [1:0] {
    WAIT_CAL,
    FILL,
    CMD,
    DONE
  } fw_state_t;

  // Mask for a word whose last filled byte lane is idx; the lanes above it are skipped.
  function automatic logic [3:0] tail_mask(input logic [1:0] idx);
    logic [3:0] m;
    m = 4'(4'b1110 << idx);
    return MASK_SKIP ? m : ~m;
  endfunction

endpackage

// File: rtl/frame_writer_if.sv
// Pixel stream plus MCB port-0 command/write signals seen by the frame writer.
interface frame_writer_if;

  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_last;
  logic        pix_ready;

  logic        p0_cmd_en;
  logic [2:0]  p0_cmd_instr;
  logic [5:0]  p0_cmd_bl;
  logic [29:0] p0_cmd_byte_addr;
  logic        p0_cmd_full;

  logic        p0_wr_en;
  logic [31:0] p0_wr_data;
  logic [3:0]  p0_wr_mask;
  logic        p0_wr_full;

  // Frame-writer side.
  modport master (
    input  pix_valid, pix_data, pix_last, p0_cmd_full, p0_wr_full,
    output pix_ready, p0_cmd_en, p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr,
    output p0_wr_en, p0_wr_data, p0_wr_mask
  );

  // Pixel source / memory controller side.
  modport slave (
    output pix_valid, pix_data, pix_last, p0_cmd_full, p0_wr_full,
    input  pix_ready, p0_cmd_en, p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr,
    input  p0_wr_en, p0_wr_data, p0_wr_mask
  );

endinterface

// File: rtl/frame_writer_pixel_packer.sv
// Packs accepted 8-bit pixels little-endian into 32-bit words; a last pixel
// closes the word early with the unfilled lanes zeroed and masked.
module pixel_packer
  import mcb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic [7:0]  pix,
  input  logic        last,
  output logic        word_end,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [3:0]  word_mask,
  output logic        word_last
);

  logic [1:0]  idx;
  logic [31:0] acc;
  logic [31:0] acc_next;

  assign word_end = accept && (last || idx == 2'd3);

  // Drop the incoming pixel into its byte lane of the word under construction.
  always_comb begin
    acc_next = acc;
    acc_next[{idx, 3'b000} +: 8] = pix;
  end

  // Accumulate lanes; emit the finished word one cycle after its closing pixel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx        <= 2'd0;
      acc        <= 32'd0;
      word_valid <= 1'b0;
      word_data  <= 32'd0;
      word_mask  <= 4'd0;
      word_last  <= 1'b0;
    end else begin
      word_valid <= word_end;
      word_last  <= word_end && last;
      if (accept) begin
        if (word_end) begin
          word_data <= acc_next;
          word_mask <= tail_mask(idx);
          acc       <= 32'd0;
          idx       <= 2'd0;
        end else begin
          acc <= acc_next;
          idx <= idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/frame_writer.sv
// Feeds the Mandelbrot pixel stream into MCB port 0: packs words, pushes them
// into the write FIFO and issues one write command per burst, wrapping the
// frame address at end of frame.
module frame_writer
  import mcb_pkg::*;
#(
  parameter int          BURST_WORDS = 16,
  parameter int          FRAME_WORDS = 76800,
  parameter logic [29:0] BASE_ADDR   = 30'h0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           calib_done,
  frame_writer_if.master bus,
  output logic           frame_done
);

  localparam int FW_W = $clog2(FRAME_WORDS + 1);

  fw_state_t       state;
  fw_state_t       state_next;
  logic [6:0]      burst_cnt;
  logic [FW_W-1:0] frame_word_cnt;
  logic [FW_W-1:0] frame_word_inc;
  logic [29:0]     burst_addr;
  logic            ended_q;
  logic            ended;
  logic            burst_full;
  logic            count_end;
  logic            accept;
  logic            issue;

  logic            word_end;
  logic            word_valid;
  logic            word_last;
  logic [31:0]     word_data;
  logic [3:0]      word_mask;

  // Once the frame's final pixel is in, nothing more is taken until DONE.
  assign bus.pix_ready = reset && (state == FILL) && !bus.p0_wr_full && !ended_q;
  assign accept        = bus.pix_valid && bus.pix_ready;

  assign frame_word_inc = frame_word_cnt + 1'b1;
  assign count_end      = (frame_word_inc == FW_W'(FRAME_WORDS));
  assign burst_full     = ((burst_cnt + 7'd1) == 7'(BURST_WORDS));
  // A word closed by pix_last is still in the packer output register on the first CMD cycle.
  assign ended          = ended_q || (word_valid && word_last);

  assign bus.p0_cmd_instr = MCB_WR;
  assign bus.p0_wr_en     = word_valid;
  assign bus.p0_wr_data   = word_data;
  assign bus.p0_wr_mask   = word_mask;

  pixel_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .accept     (accept),
    .pix        (bus.pix_data),
    .last       (bus.pix_last),
    .word_end   (word_end),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_mask  (word_mask),
    .word_last  (word_last)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= WAIT_CAL;
    else        state <= state_next;
  end

  // Next state; a burst closes when it is full or the frame ends, whichever comes first.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      WAIT_CAL: if (calib_done) state_next = FILL;
      FILL: begin
        if (word_end && (burst_full || bus.pix_last || count_end)) state_next = CMD;
      end
      CMD: begin
        if (!bus.p0_cmd_full) begin
          issue      = 1'b1;
          state_next = ended ? DONE : FILL;
        end
      end
      DONE:     state_next = FILL;
      default:  state_next = WAIT_CAL;
    endcase
  end

  // Counters, burst address and registered command/frame outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      burst_cnt            <= 7'd0;
      frame_word_cnt       <= '0;
      burst_addr           <= BASE_ADDR;
      ended_q              <= 1'b0;
      frame_done           <= 1'b0;
      bus.p0_cmd_en        <= 1'b0;
      bus.p0_cmd_bl        <= 6'd0;
      bus.p0_cmd_byte_addr <= BASE_ADDR;
    end else begin
      bus.p0_cmd_en <= issue;
      frame_done    <= (state == DONE);
      if (word_end) begin
        burst_cnt      <= burst_cnt + 7'd1;
        frame_word_cnt <= frame_word_inc;
        if (count_end) ended_q <= 1'b1;
      end
      if (word_valid && word_last) ended_q <= 1'b1;
      if (issue) begin
        bus.p0_cmd_bl        <= 6'(burst_cnt - 7'd1);
        bus.p0_cmd_byte_addr <= burst_addr;
        burst_addr           <= burst_addr + 30'({burst_cnt, 2'b00});
        burst_cnt            <= 7'd0;
      end
      if (state == DONE) begin
        burst_addr     <= BASE_ADDR;
        frame_word_cnt <= '0;
        ended_q        <= 1'b0;
      end
    end
  end

endmodule

// File: doc/frame_writer.md
# frame_writer

- Upstream stage of the video RAM: accepts the Mandelbrot engine's 8-bit pixel stream.
- Packs four pixels per 32-bit word and pushes words into the MCB port-0 write FIFO.
- After each burst, issues the DDR2 write command with the correct byte address.
- Tracks the frame address with wrap-around, flushes partial words/bursts at end of frame, and holds off until memory calibration completes.

## Interface
Parameters:
- BURST_WORDS, 16, words per write command (1..64); cmd_bl = words-1
- FRAME_WORDS, 76800, 32-bit words per frame (640x480 at 8 bpp)
- BASE_ADDR, 30'h0, frame byte base address; must be 4-byte aligned

Ports:
- clk  in  1  user clock (MCB clk0); only clock
- reset  in  1  synchronous, active-low reset
- calib_done  in  1  MCB calibration complete
- pix_valid  in  1  pixel present
- pix_data  in  8  pixel iteration count
- pix_last  in  1  qualifies the final pixel of the frame
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- p0_cmd_en  out  1  one-cycle command strobe
- p0_cmd_instr  out  3  constant 3'b000 (write)
- p0_cmd_bl  out  6  burst length minus one
- p0_cmd_byte_addr  out  30  burst start byte address
- p0_cmd_full  in  1  MCB command FIFO full
- p0_wr_en  out  1  write-FIFO push
- p0_wr_data  out  32  packed word
- p0_wr_mask  out  4  byte mask; 1 = byte not written
- p0_wr_full  in  1  MCB write FIFO full
- frame_done  out  1  one-cycle pulse after a frame's final command

## Operation
- Reset values: pix_ready=0, p0_cmd_en=0, p0_cmd_bl=0, p0_cmd_byte_addr=BASE_ADDR, p0_wr_en=0, p0_wr_data=0, p0_wr_mask=0, frame_done=0. Internal state=WAIT_CAL; counters cleared.
- Packing is little-endian. The first pixel of a word goes to [7:0] and the fourth to [31:24].
- FSM states:
  - WAIT_CAL: go to FILL when calib_done=1.
  - FILL: accept pixels. pix_ready = !p0_wr_full && !last_seen.
    - Completed word: push it; burst_cnt++.
    - burst_cnt reaches BURST_WORDS, or the final word of the frame is pushed: go to CMD.
  - CMD: hold until p0_cmd_full=0. Then assert p0_cmd_en for one cycle with bl=burst_cnt-1 and addr = burst start address.
    - Then advance the next-burst address by burst_cnt*4 and clear burst_cnt.
    - Return to FILL, or go to DONE if the frame has ended.
  - DONE: pulse frame_done for one cycle, reset address to BASE_ADDR, go to FILL.
- pix_last on byte k<3 of a word: push the partial word immediately, with mask bits [3:k+1] set and unfilled bytes zero.
- End of frame by count: when frame_word_cnt reaches FRAME_WORDS without pix_last, the address wraps to BASE_ADDR. This behaves like pix_last on a word boundary.
- pix_last on a word boundary that also completes a burst: only one command is issued (no empty burst).
- calib_done deasserting mid-frame is ignored. Calibration is checked only at reset exit.
- Reset asserted mid-burst: everything is abandoned; no command is issued for the buffered words.

## Timing
- p0_wr_en is registered and asserted the cycle after the accepting handshake of a word's 4th (or last) pixel.
- The earliest p0_cmd_en is one cycle after the final p0_wr_en of the burst. Data always precedes its command.
- Pixel stalls:
  - pix_ready=0 in WAIT_CAL, CMD and DONE.
  - pix_ready=0 in any cycle where p0_wr_full=1.
  - Sustained throughput is 1 pixel/clk except during CMD/DONE.
- frame_done is asserted the cycle after the final p0_cmd_en.
- Address arithmetic is 30-bit. The address never exceeds BASE_ADDR + FRAME_WORDS*4 - 4 within a burst.

## Structure
- Shared package mcb_pkg:
  - MCB instruction encodings: MCB_WR=3'b000, MCB_RD=3'b001.
  - Mask polarity constant.
  - Frame-writer FSM state enum.
- Natural sub-module: pixel_packer. It is the byte-to-word shift/mask register with word_valid/word_last outputs, instantiated once. The FSM, counters and address stay in frame_writer.

## Test plan
- Hold calib_done=0 for 50 cycles with pix_valid=1: pix_ready stays 0, no wr_en/cmd_en. Raise calib_done: the first pixel is accepted within 2 cycles.
- Stream 64 pixels 0x00..0x3F continuously, BURST_WORDS=16:
  - 16 wr_en.
  - First word 0x03020100, last word 0x3F3E3D3C.
  - One cmd_en with bl=15, addr=BASE_ADDR.
  - Next burst addr=BASE_ADDR+64.
- Six pixels with pix_last on the 6th: words 0x03020100 mask 0 and 0x00000504 mask 4'b1100, cmd bl=1, then frame_done pulse. The next frame starts at BASE_ADDR.
- Assert p0_cmd_full for 10 cycles when a burst completes: cmd_en is delayed until release, pix_ready=0 throughout, no lost words.
- Toggle p0_wr_full randomly during streaming: the wr_en count equals pixels/4, with data order preserved.
- FRAME_WORDS=32, BURST_WORDS=16, 128 pixels without pix_last: commands at BASE_ADDR and BASE_ADDR+64, frame_done pulses, and the 129th pixel's burst addresses BASE_ADDR.
